// File: rtl/pixel_dist_pkg.sv
// pixel_dist_pkg: state encoding, default frame geometry and round-robin pointer helper
// shared by pixel_distributor and its arbiter.
package pixel_dist_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
    localparam int DEF_X_SIZE = 640;
    localparam int DEF_Y_SIZE = 480;
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/pixel_distributor_rr_arbiter.sv
// rr_arbiter: combinational first-eligible search starting at ptr_i, wrapping mod NUM_ENGINES.
module rr_arbiter #(
    parameter int NUM_ENGINES = 4,
    parameter int ENG_IDX_W   = 2
) (
    input  logic [NUM_ENGINES-1:0] eligible_i,
    input  logic [ENG_IDX_W-1:0]   ptr_i,
    output logic                   grant_valid_o,
    output logic [ENG_IDX_W-1:0]   grant_idx_o
);
    logic [ENG_IDX_W-1:0] idx;
    // Scanning from the farthest offset down lets the closest eligible engine win last.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            idx = ENG_IDX_W'((32'(ptr_i) + 32'(i)) % NUM_ENGINES);
            if (eligible_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx;
            end
        end
    end
endmodule

// File: rtl/pixel_distributor.sv
// pixel_distributor: issues raster-ordered pixel coordinates round-robin to NUM_ENGINES engines.
// Define PIXEL_DIST_STALL_CNT_EN to add the saturating stall_cycles output.
module pixel_distributor
    import pixel_dist_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int ENG_IDX_W   = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int X_SIZE      = DEF_X_SIZE,
    parameter int Y_SIZE      = DEF_Y_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_ENGINES-1:0] engine_busy,
    input  logic [NUM_ENGINES-1:0] queue_full,
    output logic [DATA_WIDTH-1:0]  xpixel_o,
    output logic [DATA_WIDTH-1:0]  ypixel_o,
    output logic [NUM_ENGINES-1:0] issue_o,
    output logic                   busy_o,
    output logic                   frame_done
`ifdef PIXEL_DIST_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);
    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  x_q, x_d, y_q, y_d, xpix_q, xpix_d, ypix_q, ypix_d;
    logic [ENG_IDX_W-1:0]   ptr_q, ptr_d, grant_idx;
    logic [NUM_ENGINES-1:0] issue_q, issue_d, eligible;
    logic                   grant_valid, x_last, y_last, busy_q, done_q;

    // Masking last cycle's grant covers the engine's one-cycle busy latency.
    assign eligible = ~engine_busy & ~queue_full & ~issue_q;
    assign x_last   = x_q == DATA_WIDTH'(X_SIZE - 1);
    assign y_last   = y_q == DATA_WIDTH'(Y_SIZE - 1);

    rr_arbiter #(
        .NUM_ENGINES(NUM_ENGINES),
        .ENG_IDX_W  (ENG_IDX_W)
    ) u_arb (
        .eligible_i   (eligible),
        .ptr_i        (ptr_q),
        .grant_valid_o(grant_valid),
        .grant_idx_o  (grant_idx)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ptr_d   = ptr_q;
        issue_d = '0;
        xpix_d  = xpix_q;
        ypix_d  = ypix_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ISSUE;
                x_d     = '0;
                y_d     = '0;
            end
            ISSUE: if (grant_valid) begin
                issue_d = NUM_ENGINES'(1) << grant_idx;
                xpix_d  = x_q;
                ypix_d  = y_q;
                ptr_d   = ENG_IDX_W'(next_ptr(32'(grant_idx), NUM_ENGINES));
                x_d     = x_last ? '0 : x_q + DATA_WIDTH'(1);
                y_d     = !x_last ? y_q : (y_last ? '0 : y_q + DATA_WIDTH'(1));
                state_d = (x_last && y_last) ? DRAIN : ISSUE;
            end
            DRAIN: state_d = (engine_busy == '0 && issue_q == '0) ? DONE : DRAIN;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ptr_q   <= '0;
            issue_q <= '0;
            xpix_q  <= '0;
            ypix_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ptr_q   <= ptr_d;
            issue_q <= issue_d;
            xpix_q  <= xpix_d;
            ypix_q  <= ypix_d;
            busy_q  <= state_d == ISSUE || state_d == DRAIN;
            done_q  <= state_d == DONE;
        end
    end

    assign xpixel_o   = xpix_q;
    assign ypixel_o   = ypix_q;
    assign issue_o    = issue_q;
    assign busy_o     = busy_q;
    assign frame_done = done_q;

`ifdef PIXEL_DIST_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk) begin
        if (reset || (state_q == IDLE && start))
            stall_q <= '0;
        else if (state_q == ISSUE && !grant_valid && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end
    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_pixel_distributor.sv
// tb_pixel_distributor: directed and randomized checks of pixel_distributor against a
// pixel-index reference model, with emulated engines that go busy the cycle after issue.
module tb_pixel_distributor;
    localparam int N  = 4;
    localparam int XS = 4;
    localparam int YS = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  engine_busy = '0;
    logic [N-1:0]  queue_full = '0;
    logic [DW-1:0] xpixel_o, ypixel_o;
    logic [N-1:0]  issue_o;
    logic          busy_o, frame_done;
`ifdef PIXEL_DIST_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    pixel_distributor #(
        .NUM_ENGINES(N),
        .ENG_IDX_W  (2),
        .DATA_WIDTH (DW),
        .X_SIZE     (XS),
        .Y_SIZE     (YS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .engine_busy(engine_busy),
        .queue_full (queue_full),
        .xpixel_o   (xpixel_o),
        .ypixel_o   (ypixel_o),
        .issue_o    (issue_o),
        .busy_o     (busy_o),
        .frame_done (frame_done)
`ifdef PIXEL_DIST_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    int m_phase = 0, m_n = 0, m_ptr = 0, m_x = 0, m_y = 0;
    logic [N-1:0] m_issue = '0;
    bit m_busy = 1'b0, m_done = 1'b0;
    longint m_stall = 0;
    int cnt[N];
    logic [N-1:0] force_busy = '0;
    int dur_max = 1;
    int log_eng[$], log_x[$], log_y[$], log_cyc[$];
    int done_cnt = 0, dut_done_cnt = 0, done_cyc = 0;
    int t1_eng[5] = '{0, 1, 2, 3, 0};
    int t1_x[5]   = '{0, 1, 2, 3, 0};
    int t1_y[5]   = '{0, 0, 0, 0, 1};
    int t2_eng[8] = '{0, 2, 3, 0, 2, 3, 0, 2};

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    // Model tracks the frame as a linear pixel index; coordinates are derived by div/mod.
    task automatic model_update();
        if (reset) begin
            m_phase = 0; m_n = 0; m_ptr = 0; m_issue = '0; m_x = 0; m_y = 0; m_stall = 0;
        end else begin
            case (m_phase)
                0: if (start) begin m_phase = 1; m_n = 0; m_stall = 0; end
                1: begin
                    int g = -1;
                    for (int k = 0; k < N; k++) begin
                        int e = (m_ptr + k) % N;
                        if (g < 0 && !engine_busy[e] && !queue_full[e] && !m_issue[e]) g = e;
                    end
                    m_issue = '0;
                    if (g >= 0) begin
                        m_issue[g] = 1'b1;
                        m_x = m_n % XS;
                        m_y = m_n / XS;
                        m_ptr = (g + 1) % N;
                        m_n++;
                        if (m_n == XS * YS) m_phase = 2;
                    end else if (m_stall < 64'hFFFF_FFFF) m_stall++;
                end
                2: begin
                    if (engine_busy == '0 && m_issue == '0) m_phase = 3;
                    m_issue = '0;
                end
                default: m_phase = 0;
            endcase
        end
        m_busy = m_phase == 1 || m_phase == 2;
        m_done = m_phase == 3;
    endtask

    task automatic compare();
        check("issue_o", issue_o, m_issue);
        if (m_issue != '0) begin
            check("xpixel_o", xpixel_o, m_x);
            check("ypixel_o", ypixel_o, m_y);
        end
        check("busy_o", busy_o, m_busy);
        check("frame_done", frame_done, m_done);
`ifdef PIXEL_DIST_STALL_CNT_EN
        check("stall_cycles", stall_cycles, m_stall);
`endif
        for (int e = 0; e < N; e++)
            if (m_issue[e]) begin
                log_eng.push_back(e); log_x.push_back(m_x); log_y.push_back(m_y); log_cyc.push_back(cyc);
            end
        if (m_done) begin done_cnt++; done_cyc = cyc; end
        if (frame_done) dut_done_cnt++;
    endtask

    // Engines see issue in cycle k, raise busy from cycle k+1 for a few cycles.
    task automatic drive();
        for (int e = 0; e < N; e++) begin
            engine_busy[e] = cnt[e] > 0 || force_busy[e];
            if (cnt[e] > 0) cnt[e]--;
            if (issue_o[e]) cnt[e] = (dur_max <= 1) ? 1 : int'($urandom_range(dur_max, 1));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        compare();
        drive();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic clear_logs();
        log_eng.delete(); log_x.delete(); log_y.delete(); log_cyc.delete();
        done_cnt = 0; dut_done_cnt = 0;
    endtask

    task automatic run_frame(input int budget);
        int c = 0;
        while (!m_done && c < budget) begin step(); c++; end
        check("frame_completes", m_done, 1);
    endtask

    task automatic check_order(input string name);
        check({name, "_count"}, log_eng.size(), XS * YS);
        for (int i = 0; i < log_x.size(); i++) begin
            check({name, "_x"}, log_x[i], i % XS);
            check({name, "_y"}, log_y[i], i / XS);
        end
    endtask

    initial begin
        int start_c, rel_c, e0, c;
        step(); step();
        check("rst_issue", issue_o, 0);
        check("rst_x", xpixel_o, 0);
        check("rst_y", ypixel_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", frame_done, 0);
        reset = 1'b0;
        step();

        clear_logs();
        start_c = cyc;
        pulse_start();
        run_frame(100);
        check_order("t1");
        for (int i = 0; i < 5; i++) begin
            check("t1_eng", log_eng[i], t1_eng[i]);
            check("t1_x_lit", log_x[i], t1_x[i]);
            check("t1_y_lit", log_y[i], t1_y[i]);
        end
        check("t1_latency", log_cyc[0] - start_c, 2);
        check("t1_back_to_back", log_cyc[7] - log_cyc[0], 7);
        check("t1_done_gap", done_cyc - log_cyc[7], 3);
        step(); step();

        clear_logs();
        queue_full = 4'b0010;
        pulse_start();
        run_frame(100);
        queue_full = '0;
        check_order("t2");
        for (int i = 0; i < 8; i++) check("t2_eng", log_eng[i], t2_eng[i]);
        step(); step();

        clear_logs();
        pulse_start();
        repeat (3) step();
        queue_full = '1;
        repeat (20) step();
        queue_full = '0;
        run_frame(100);
        check_order("t3");
        check("t3_stall_model", m_stall, 20);
        check("t3_resume_gap", log_cyc[3] - log_cyc[2], 21);
        step(); step();

        clear_logs();
        pulse_start();
        step();
        force_busy[0] = 1'b1;
        repeat (10) step();
        rel_c = cyc;
        force_busy[0] = 1'b0;
        run_frame(100);
        check_order("t4");
        e0 = 0;
        foreach (log_eng[i]) if (log_eng[i] == 0) e0++;
        check("t4_eng0_issues", e0, 1);
        check("t4_done_after_release", done_cyc > rel_c, 1);
        step(); step();

        clear_logs();
        pulse_start();
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_issue", issue_o, 0);
        check("t5_x", xpixel_o, 0);
        check("t5_y", ypixel_o, 0);
        check("t5_busy", busy_o, 0);
        check("t5_done", frame_done, 0);
        step();
        clear_logs();
        pulse_start();
        run_frame(100);
        check_order("t5");
        check("t5_first_eng", log_eng[0], 0);
        step(); step();

        clear_logs();
        pulse_start();
        step(); step();
        pulse_start();
        c = 0;
        while (m_phase != 3 && c < 100) begin step(); c++; end
        check("t6_reached_done", m_phase, 3);
        pulse_start();
        repeat (5) step();
        check_order("t6");
        check("t6_model_dones", done_cnt, 1);
        check("t6_dut_dones", dut_done_cnt, 1);
        check("t6_idle_busy", busy_o, 0);

        clear_logs();
        dur_max = 5;
        repeat (3000) begin
            queue_full = ($urandom_range(3, 0) == 0) ? N'($urandom) : '0;
            start = $urandom_range(7, 0) == 0;
            reset = $urandom_range(299, 0) == 0;
            step();
        end
        start = 1'b0; reset = 1'b0; queue_full = '0;
        repeat (40) step();
        check("rand_frame_count", dut_done_cnt, done_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pixel_distributor.md
Name: pixel_distributor

Overview:
Frame scheduler that hands raster-ordered pixel coordinates to NUM_ENGINES parallel compute engines, one pixel per engine per issue.
- Round-robin arbitration across engines; an engine is skipped while it is busy or its per-engine result queue reports full.
- Sits between the frame-start control and the engine array. Each engine's result queue feeds the combinator, which restores raster order.

Parameters:
NUM_ENGINES, 4, number of engines sharing the pixel stream (>=2)
ENG_IDX_W, 2, width of engine index, $clog2(NUM_ENGINES)
DATA_WIDTH, 32, coordinate width, matches engine/queue coordinate ports
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle frame start request
engine_busy  in  NUM_ENGINES  per-engine busy; asserts the cycle after issue, deasserts when the result is handed to its queue
queue_full  in  NUM_ENGINES  per-engine result-queue full flag
xpixel_o  out  DATA_WIDTH  issued x coordinate, valid with issue_o
ypixel_o  out  DATA_WIDTH  issued y coordinate, valid with issue_o
issue_o  out  NUM_ENGINES  one-hot, one-cycle start pulse to the granted engine; all zero when idle
busy_o  out  1  high in ISSUE and DRAIN
frame_done  out  1  one-cycle pulse when the frame is fully issued and all engines are idle

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE; x_cnt=y_cnt=0; rr pointer=0; issue_o=0; xpixel_o=ypixel_o=0; busy_o=0; frame_done=0. A reset mid-frame abandons the frame. No pending issue survives.
- All outputs are registered.
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on start=1, clear counters and go to ISSUE. start is ignored in every other state.
  - ISSUE: each cycle, compute eligible[i] = !engine_busy[i] && !queue_full[i] && !issue_o[i]. The issue_o term masks the engine granted in the previous cycle, covering its one-cycle busy latency.
    - If any engine is eligible, grant the first eligible index searching from ptr upward, wrapping mod NUM_ENGINES.
    - On a grant, next cycle: issue_o=onehot(g), xpixel_o=x_cnt, ypixel_o=y_cnt, ptr=g+1 mod NUM_ENGINES.
    - Counter advance: x_cnt+1; at X_SIZE-1 wrap x_cnt to 0 and increment y_cnt.
    - If no engine is eligible, issue_o=0 and the counters hold (stall).
    - Issuing pixel (X_SIZE-1, Y_SIZE-1) moves the FSM to DRAIN.
    - At most one issue per cycle.
  - DRAIN: issue_o=0. Leave when engine_busy==0 and issue_o==0, then go to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE. busy_o=0 in DONE.
- Latency: start to first issue_o is 2 cycles (IDLE->ISSUE, then registered grant), given an eligible engine.
- Counter widths: x_cnt and y_cnt are DATA_WIDTH, zero-extended onto the outputs. No value ever exceeds X_SIZE-1 or Y_SIZE-1.
- Boundaries:
  - All queues full: indefinite stall, no coordinate skipped or duplicated.
  - start in the same cycle as DONE: ignored.
  - queue_full asserting in the same cycle a grant is computed: that engine is ineligible that cycle.
  - X_SIZE=1: every issue advances y.

Optional Feature:
PIXEL_DIST_STALL_CNT_EN
- Defined: adds output stall_cycles (32 bits).
  - Cleared on reset and on start accepted in IDLE.
  - Increments each ISSUE cycle with no grant; saturates at all-ones.
  - Holds its value after the frame.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package pixel_dist_pkg holds:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - default X_SIZE/Y_SIZE constants;
  - function next_ptr(ptr, n).
- Sub-module rr_arbiter (params NUM_ENGINES, ENG_IDX_W): inputs eligible and ptr; outputs grant_valid and grant_idx. Purely combinational; the pointer register lives in pixel_distributor.

Test Plan:
- X_SIZE=4, Y_SIZE=2, 4 engines, all idle, start: issues go to engines 0,1,2,3,0,... Coordinates (0,0),(1,0),(2,0),(3,0),(0,1),... One issue every cycle. frame_done fires 1 cycle after the last engine goes idle.
- queue_full=4'b0010 held for the whole frame: engine 1 never receives issue_o; grant order 0,2,3,0,2,3. All 8 coordinates issued exactly once, in order.
- queue_full=4'b1111 for 20 cycles mid-frame: issue_o=0 and coordinates hold. After release, issuing resumes at the next unissued coordinate. With the macro, stall_cycles=20.
- engine_busy[0] held high for 10 cycles after its first issue: engine 0 is skipped and the others rotate. DRAIN waits for engine 0 before frame_done.
- reset asserted 3 cycles into a frame: next cycle all outputs are 0 and state is IDLE. A new start restarts at (0,0) with engine 0.
- start pulsed during ISSUE and during DONE: ignored, no counter disturbance, exactly one frame_done per frame.
